// File: rtl/instr_pkg.sv
// rtl/instr_pkg.sv - shared instruction word layout for instruction_encode and instructiondecode
//
// Purpose : a single definition of the instruction word layout. Both the encoder and the
//           decoder import it, so the two ends cannot drift apart.
// Contents: iw_calc() and field-offset functions for any parameter set, plus localparams
//           evaluated at the default parameters.
//           There are no ports (package).
package instr_pkg;

    localparam int WIDTH_D    = 4;
    localparam int HEIGHT_D   = 3;
    localparam int MISC_AMT_D = 9;
    localparam int OP_SIZE_D  = 1;

    // Field order, LSB first: shape, x1, y1, x2, y2, x3, y3, r, g, b, misc, op_code.
    function automatic int iw_calc(input int w, input int h, input int m, input int o);
        return 3 * (w + h) + 25 + o + m;
    endfunction

    function automatic int r_off(input int w, input int h);
        return 3 * (w + h) + 1;
    endfunction

    localparam int IW_D       = iw_calc(WIDTH_D, HEIGHT_D, MISC_AMT_D, OP_SIZE_D);
    localparam int X1_OFF     = 1;
    localparam int Y1_OFF     = WIDTH_D + 1;
    localparam int R_OFF      = r_off(WIDTH_D, HEIGHT_D);
    localparam int G_OFF      = R_OFF + 8;
    localparam int B_OFF      = R_OFF + 16;
    localparam int MISC_OFF   = R_OFF + 24;
    localparam int OP_OFF     = R_OFF + 24 + MISC_AMT_D;

endpackage

// File: rtl/instruction_encode_if.sv
// rtl/instruction_encode_if.sv - field-set input and instruction output handshake bundle
//
// Purpose : groups the producer side (in_valid/in_ready plus the field set) and the
//           consumer side (out_valid/out_ready/instruction) together with the occupancy.
// Modports: master - the command source and the instruction consumer (testbench side).
//           slave  - the encoder.
interface instruction_encode_if
    import instr_pkg::*;
#(
    parameter int width    = 4,
    parameter int height   = 3,
    parameter int misc_amt = 9,
    parameter int op_size  = 1,
    parameter int DEPTH    = 4
);
    localparam int IW = iw_calc(width, height, misc_amt, op_size);
    localparam int CW = $clog2(DEPTH + 1);

    logic                in_valid;
    logic                in_ready;
    logic                shape;
    logic [width-1:0]    x1, x2, x3;
    logic [height-1:0]   y1, y2, y3;
    logic [7:0]          r, g, b;
    logic [misc_amt-1:0] misc;
    logic [op_size-1:0]  op_code;
    logic                out_valid;
    logic                out_ready;
    logic [IW-1:0]       instruction;
    logic [CW-1:0]       fifo_count;

    modport master (
        output in_valid, shape, x1, x2, x3, y1, y2, y3, r, g, b, misc, op_code, out_ready,
        input  in_ready, out_valid, instruction, fifo_count
    );

    modport slave (
        input  in_valid, shape, x1, x2, x3, y1, y2, y3, r, g, b, misc, op_code, out_ready,
        output in_ready, out_valid, instruction, fifo_count
    );

endinterface

// File: rtl/instr_fifo.sv
// rtl/instr_fifo.sv - show-ahead FIFO with synchronous flush and no full-side bypass
//
// Ports: clk, reset_n (async active-low), flush (sync clear),
//        wr_valid/wr_ready/wr_data (write side), rd_valid/rd_ready/rd_data (read side),
//        count (occupancy, 0..DEPTH).
module instr_fifo #(
    parameter int W     = 56,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [W-1:0]               wr_data,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [W-1:0]               rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    // Full means not ready even if a pop happens this cycle.
    assign wr_ready = (count != CW'(DEPTH));
    assign rd_valid = (count != '0);
    assign push     = wr_valid & wr_ready;
    assign pop      = rd_valid & rd_ready;
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

    // Storage needs no reset: stale entries are never visible while count is 0.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/instruction_encode.sv
// rtl/instruction_encode.sv - packs shape-command fields into instruction words and buffers them
//
// Ports: clk, reset_n (async active-low), flush (sync FIFO clear),
//        bus (instruction_encode_if.slave): field set in with in_valid/in_ready,
//        instruction out with out_valid/out_ready, fifo_count occupancy.
module instruction_encode
    import instr_pkg::*;
#(
    parameter int width    = 4,
    parameter int height   = 3,
    parameter int misc_amt = 9,
    parameter int op_size  = 1,
    parameter int DEPTH    = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    instruction_encode_if.slave  bus
);
    localparam int IW = iw_calc(width, height, misc_amt, op_size);

    logic [IW-1:0] packed_word;

    // Concatenation order is the layout, MSB first: op_code down to shape at bit 0.
    assign packed_word = {bus.op_code, bus.misc, bus.b, bus.g, bus.r,
                          bus.y3, bus.x3, bus.y2, bus.x2, bus.y1, bus.x1, bus.shape};

    instr_fifo #(
        .W     (IW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (flush),
        .wr_valid (bus.in_valid),
        .wr_ready (bus.in_ready),
        .wr_data  (packed_word),
        .rd_valid (bus.out_valid),
        .rd_ready (bus.out_ready),
        .rd_data  (bus.instruction),
        .count    (bus.fifo_count)
    );

endmodule

// File: tb/tb_instruction_encode.sv
// tb/tb_instruction_encode.sv - self-checking bench for instruction_encode
module tb_instruction_encode;
    localparam int W = 4;
    localparam int H = 3;
    localparam int M = 9;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic       op;
        logic [8:0] misc;
        logic [7:0] b;
        logic [7:0] g;
        logic [7:0] r;
        logic [2:0] y3;
        logic [3:0] x3;
        logic [2:0] y2;
        logic [3:0] x2;
        logic [2:0] y1;
        logic [3:0] x1;
        logic       shape;
    } fields_t;

    logic clk;
    logic reset_n;
    logic flush;
    int   checks;
    int   errors;
    fields_t q[$];

    instruction_encode_if bus ();

    instruction_encode dut (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint unsigned pack_model(input fields_t f);
        longint unsigned w;
        int ro;
        ro = 3 * (W + H) + 1;
        w  = longint'(f.shape);
        w += longint'(f.x1) << 1;
        w += longint'(f.y1) << (1 + W);
        w += longint'(f.x2) << (1 + W + H);
        w += longint'(f.y2) << (1 + 2 * W + H);
        w += longint'(f.x3) << (1 + 2 * (W + H));
        w += longint'(f.y3) << (1 + 3 * W + 2 * H);
        w += longint'(f.r) << ro;
        w += longint'(f.g) << (ro + 8);
        w += longint'(f.b) << (ro + 16);
        w += longint'(f.misc) << (ro + 24);
        w += longint'(f.op) << (ro + 24 + M);
        return w;
    endfunction

    function automatic fields_t decode(input longint unsigned w);
        fields_t d;
        int ro;
        ro = 3 * (W + H) + 1;
        d.shape = 1'(w & 1);
        d.x1    = 4'((w >> 1) % 16);
        d.y1    = 3'((w >> (1 + W)) % 8);
        d.x2    = 4'((w >> (1 + W + H)) % 16);
        d.y2    = 3'((w >> (1 + 2 * W + H)) % 8);
        d.x3    = 4'((w >> (1 + 2 * (W + H))) % 16);
        d.y3    = 3'((w >> (1 + 3 * W + 2 * H)) % 8);
        d.r     = 8'((w >> ro) % 256);
        d.g     = 8'((w >> (ro + 8)) % 256);
        d.b     = 8'((w >> (ro + 16)) % 256);
        d.misc  = 9'((w >> (ro + 24)) % 512);
        d.op    = 1'((w >> (ro + 24 + M)) % 2);
        return d;
    endfunction

    function automatic fields_t rand_fields();
        fields_t f;
        f = {$urandom, $urandom};
        return f;
    endfunction

    // Drives one cycle of stimulus from a negedge, advances the occupancy model at the
    // posedge and returns at the following negedge.
    task automatic step(input fields_t f, input bit v, input bit rdy, input bit fl);
        bit push;
        bit pop;
        fields_t tmp;
        bus.in_valid  = v;
        bus.out_ready = rdy;
        flush         = fl;
        bus.shape = f.shape; bus.x1 = f.x1; bus.y1 = f.y1; bus.x2 = f.x2; bus.y2 = f.y2;
        bus.x3 = f.x3; bus.y3 = f.y3; bus.r = f.r; bus.g = f.g; bus.b = f.b;
        bus.misc = f.misc; bus.op_code = f.op;
        push = v && (q.size() != DEPTH);
        pop  = rdy && (q.size() != 0);
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (pop) tmp = q.pop_front();
            if (push) q.push_back(f);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        flush         = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        checks++;
        if (bus.instruction !== 56'h0) begin errors++; $display("FAIL reset_instruction got=%h want=0", bus.instruction); end
        checks++;
        if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", bus.fifo_count); end
    endtask

    task automatic test_pack_vectors();
        fields_t f;
        logic [55:0] want [3];
        want[0] = 56'h00_0000_0000_001F;
        want[1] = 56'h00_0000_3FC0_0000;
        want[2] = 56'h80_0000_0000_0000;
        for (int i = 0; i < 3; i++) begin
            f = '0;
            if (i == 0) begin f.shape = 1'b1; f.x1 = 4'hF; end
            if (i == 1) f.r = 8'hFF;
            if (i == 2) f.op = 1'b1;
            step(f, 1'b1, 1'b0, 1'b0);
            checks++;
            if (bus.instruction !== want[i] || bus.out_valid !== 1'b1)
                begin errors++; $display("FAIL pack_vector%0d got=%h v=%b want=%h", i, bus.instruction, bus.out_valid, want[i]); end
            step('0, 1'b0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_fill();
        fields_t w [5];
        for (int i = 0; i < 5; i++) begin
            w[i] = rand_fields();
            w[i].misc = 9'(i);
        end
        for (int i = 0; i < 4; i++) step(w[i], 1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.in_ready !== 1'b0 || bus.fifo_count !== 3'd4)
            begin errors++; $display("FAIL fill_full got rdy=%b cnt=%0d want rdy=0 cnt=4", bus.in_ready, bus.fifo_count); end
        step(w[4], 1'b1, 1'b0, 1'b0);
        step(w[4], 1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.fifo_count !== 3'd4 || bus.instruction !== 56'(pack_model(w[0])))
            begin errors++; $display("FAIL fill_hold got cnt=%0d ins=%h want cnt=4 ins=%h", bus.fifo_count, bus.instruction, 56'(pack_model(w[0]))); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.instruction !== 56'(pack_model(w[i])))
                begin errors++; $display("FAIL drain%0d got v=%b ins=%h want %h", i, bus.out_valid, bus.instruction, 56'(pack_model(w[i]))); end
            step('0, 1'b0, 1'b1, 1'b0);
        end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.instruction !== 56'h0)
            begin errors++; $display("FAIL drain_empty got v=%b ins=%h want v=0 ins=0", bus.out_valid, bus.instruction); end
    endtask

    task automatic test_back_to_back();
        fields_t exp_q[$];
        fields_t f;
        for (int i = 0; i < 2; i++) begin
            f = rand_fields();
            exp_q.push_back(f);
            step(f, 1'b1, 1'b0, 1'b0);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (bus.instruction !== 56'(pack_model(exp_q[0])))
                begin errors++; $display("FAIL b2b_data%0d got=%h want=%h", i, bus.instruction, 56'(pack_model(exp_q[0]))); end
            f = rand_fields();
            step(f, 1'b1, 1'b1, 1'b0);
            void'(exp_q.pop_front());
            exp_q.push_back(f);
            checks++;
            if (bus.fifo_count !== 3'd2)
                begin errors++; $display("FAIL b2b_count%0d got=%0d want=2", i, bus.fifo_count); end
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (bus.instruction !== 56'(pack_model(exp_q[i])))
                begin errors++; $display("FAIL b2b_tail%0d got=%h want=%h", i, bus.instruction, 56'(pack_model(exp_q[i]))); end
            step('0, 1'b0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) step(rand_fields(), 1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.fifo_count !== 3'd3) begin errors++; $display("FAIL flush_pre got=%0d want=3", bus.fifo_count); end
        step(rand_fields(), 1'b1, 1'b1, 1'b1);
        checks++;
        if (bus.fifo_count !== 3'd0 || bus.out_valid !== 1'b0 || bus.instruction !== 56'h0 || bus.in_ready !== 1'b1)
            begin errors++; $display("FAIL flush got cnt=%0d v=%b ins=%h rdy=%b want 0 0 0 1", bus.fifo_count, bus.out_valid, bus.instruction, bus.in_ready); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 2; i++) step(rand_fields(), 1'b1, 1'b0, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.fifo_count !== 3'd0 || bus.instruction !== 56'h0)
            begin errors++; $display("FAIL async_reset got v=%b cnt=%0d ins=%h want 0 0 0", bus.out_valid, bus.fifo_count, bus.instruction); end
        q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.fifo_count !== 3'd0)
            begin errors++; $display("FAIL async_release got rdy=%b cnt=%0d want 1 0", bus.in_ready, bus.fifo_count); end
    endtask

    task automatic test_random();
        bit v;
        bit rdy;
        bit fl;
        for (int i = 0; i < 1000; i++) begin
            checks++;
            if (bus.fifo_count !== 3'(q.size()) || bus.in_ready !== (q.size() != DEPTH) || bus.out_valid !== (q.size() != 0))
                begin errors++; $display("FAIL rand_flags%0d got cnt=%0d rdy=%b v=%b want cnt=%0d", i, bus.fifo_count, bus.in_ready, bus.out_valid, q.size()); end
            checks++;
            if (q.size() != 0) begin
                if (bus.instruction !== 56'(pack_model(q[0])) || decode(64'(bus.instruction)) !== q[0])
                    begin errors++; $display("FAIL rand_data%0d got=%h want=%h", i, bus.instruction, 56'(pack_model(q[0]))); end
            end else if (bus.instruction !== 56'h0) begin
                errors++; $display("FAIL rand_idle%0d got=%h want=0", i, bus.instruction);
            end
            v   = (i < 500) ? ($urandom_range(9) < 7) : ($urandom_range(9) < 4);
            rdy = (i < 500) ? ($urandom_range(9) < 4) : ($urandom_range(9) < 7);
            fl  = ($urandom_range(63) == 0);
            step(rand_fields(), v, rdy, fl);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        {bus.shape, bus.x1, bus.y1, bus.x2, bus.y2, bus.x3, bus.y3} = '0;
        {bus.r, bus.g, bus.b, bus.misc, bus.op_code} = '0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_pack_vectors();
        test_fill();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
